// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the multiplexed seven-segment scan
// controller.
//   scan_state_t : scan FSM states (idle / blanking gap / digit lit)
//   SEG_OFF      : active-low segment pattern with every segment dark
//   CODE_W       : width of one digit code presented to the shared decoder
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int         CODE_W  = 5;

endpackage

// File: rtl/seg7_dwell_timer.sv
// ---------------------------------------------------------------------------
// seg7_dwell_timer
// Dwell counter shared by the blanking and lit phases of the scan FSM.
// Counts up from zero after a clear and raises done on the cycle the count
// reaches limit-1. The count parks there instead of wrapping, so done stays
// high until the owner clears it.
// Ports:
//   clk    in   1       system clock, rising edge
//   rst_n  in   1       asynchronous reset, active low
//   clear  in   1       synchronous restart of the count at zero
//   limit  in   CNT_W   phase length in cycles (must be >= 1)
//   done   out  1       high while count == limit-1
// ---------------------------------------------------------------------------
module seg7_dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    assign done = (r_count == (limit - 1'b1));

    // Count register: cleared on request, otherwise advances until it
    // reaches the terminal value and holds there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!done) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexes N_DIGITS 5-bit digit codes through one external 5-to-7
// segment decoder. Each digit is preceded by a blanking gap with every anode
// off to stop ghosting. A new display word is accepted by valid/ready into a
// shadow buffer and only copied to the live buffer at a frame boundary (or
// straight away while idle), so a frame never shows a mix of two words.
//
// Optional feature macro: SEG7_SCAN_DP_EN adds a per-digit decimal point
// mask (load_dp) buffered exactly like load_data, and an active-low dp pin.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            asynchronous reset, active low
//   enable      in   1            1 = scan, 0 = go dark
//   load_valid  in   1            new display word offered
//   load_ready  out  1            word can be accepted
//   load_data   in   5*N_DIGITS   digit k = load_data[5k+4:5k], digit 0 rightmost
//   line        out  5            code currently driven to the shared decoder
//   seg_in      in   7            decoder result for line, active low
//   seg         out  7            registered segments to pins, active low
//   an          out  N_DIGITS     anodes, active low, at most one low
//   frame_tick  out  1            pulse on the last cycle of the last digit
//   load_dp     in   N_DIGITS     (SEG7_SCAN_DP_EN) decimal point mask
//   dp          out  1            (SEG7_SCAN_DP_EN) decimal point, active low
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [CODE_W*N_DIGITS-1:0]   load_data,
    output logic [CODE_W-1:0]            line,
    input  logic [6:0]                   seg_in,
    output logic [6:0]                   seg,
    output logic [N_DIGITS-1:0]          an,
    output logic                         frame_tick
`ifdef SEG7_SCAN_DP_EN
    ,
    input  logic [N_DIGITS-1:0]          load_dp,
    output logic                         dp
`endif
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    scan_state_t                      r_state;
    scan_state_t                      w_nextState;
    logic [IDX_W-1:0]                 r_idx;
    logic [N_DIGITS-1:0][CODE_W-1:0]  r_disp;
    logic [N_DIGITS-1:0][CODE_W-1:0]  r_shadow;
    logic                             r_pending;
    logic [6:0]                       r_seg;

    logic [CNT_W-1:0]                 w_limit;
    logic                             w_timerClear;
    logic                             w_timerDone;
    logic                             w_segOff;
    logic                             w_segCapture;
    logic                             w_idxAdvance;
    logic                             w_idxZero;
    logic                             w_frameTick;
    logic                             w_lastDigit;
    logic                             w_transfer;
    logic                             w_commit;

    // The timer length follows the current phase. Kept outside the FSM
    // process so the FSM only consumes done and never feeds its own input.
    assign w_limit     = (r_state == S_SHOW) ? CNT_W'(SHOW_CYC) : CNT_W'(BLANK_CYC);
    assign w_lastDigit = (r_idx == IDX_W'(N_DIGITS - 1));

    seg7_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwellTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_timerClear),
        .limit (w_limit),
        .done  (w_timerDone)
    );

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-cycle control. Dropping enable overrides every
    // state: the display goes dark next cycle, the scan restarts at digit 0
    // and no frame_tick is produced. Segments are forced dark on every entry
    // to BLANK and captured from the decoder on the last BLANK cycle, when
    // line has been stable for the whole gap.
    always_comb begin
        w_nextState  = r_state;
        w_timerClear = 1'b0;
        w_segOff     = 1'b0;
        w_segCapture = 1'b0;
        w_idxAdvance = 1'b0;
        w_idxZero    = 1'b0;
        w_frameTick  = 1'b0;
        if (!enable) begin
            w_nextState  = S_IDLE;
            w_timerClear = 1'b1;
            w_segOff     = 1'b1;
            w_idxZero    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nextState  = S_BLANK;
                    w_timerClear = 1'b1;
                    w_segOff     = 1'b1;
                end
                S_BLANK: begin
                    if (w_timerDone) begin
                        w_nextState  = S_SHOW;
                        w_timerClear = 1'b1;
                        w_segCapture = 1'b1;
                    end
                end
                S_SHOW: begin
                    if (w_timerDone) begin
                        w_nextState  = S_BLANK;
                        w_timerClear = 1'b1;
                        w_segOff     = 1'b1;
                        w_idxAdvance = 1'b1;
                        w_frameTick  = w_lastDigit;
                    end
                end
                default: begin
                    w_nextState  = S_IDLE;
                    w_timerClear = 1'b1;
                    w_segOff     = 1'b1;
                    w_idxZero    = 1'b1;
                end
            endcase
        end
    end

    // Digit index: wraps to 0 after the last digit, forced to 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_idxZero) begin
            r_idx <= '0;
        end else if (w_idxAdvance) begin
            r_idx <= w_lastDigit ? '0 : r_idx + 1'b1;
        end
    end

    // Registered segment pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
        end else if (w_segOff) begin
            r_seg <= SEG_OFF;
        end else if (w_segCapture) begin
            r_seg <= seg_in;
        end
    end

    // Load handshake and double buffer. Ready is low while a word waits in
    // the shadow, so a transfer and a commit can never share a cycle; if
    // they ever did, the new word would remain pending behind the commit.
    assign w_transfer = load_valid & ~r_pending;
    assign w_commit   = r_pending & (w_frameTick | (r_state == S_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_disp <= r_shadow;
            end
            if (w_transfer) begin
                r_shadow  <= load_data;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    a_noTransferDuringCommit : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_transfer && w_commit)
    );

    // Anodes are a pure function of state and index, so only the lit digit
    // can ever be low.
    always_comb begin
        an = '1;
        if (r_state == S_SHOW) begin
            an[r_idx] = 1'b0;
        end
    end

    assign load_ready = ~r_pending;
    assign line       = r_disp[r_idx];
    assign seg        = r_seg;
    assign frame_tick = w_frameTick;

`ifdef SEG7_SCAN_DP_EN
    logic [N_DIGITS-1:0] r_dpDisp;
    logic [N_DIGITS-1:0] r_dpShadow;

    // Decimal point mask follows the same shadow/commit path as the codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dpDisp   <= '0;
            r_dpShadow <= '0;
        end else begin
            if (w_commit) begin
                r_dpDisp <= r_dpShadow;
            end
            if (w_transfer) begin
                r_dpShadow <= load_dp;
            end
        end
    end

    assign dp = (r_state == S_SHOW) ? ~r_dpDisp[r_idx] : 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with N_DIGITS=4, SHOW_CYC=6,
// BLANK_CYC=2 and a behavioural seven-segment decoder closing the line ->
// seg_in loop. With SEG7_SCAN_DP_EN defined it also checks the dp pin.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N_DIGITS  = 4;
    localparam int SHOW_CYC  = 6;
    localparam int BLANK_CYC = 2;
    localparam int CNT_W     = 16;
    localparam int N_VECS    = 128;

    localparam logic [19:0] WORD_W = {5'd8, 5'd3, 5'd1, 5'd0};
    localparam logic [19:0] WORD_A = {5'd2, 5'd4, 5'd6, 5'd9};
    localparam logic [19:0] WORD_B = {5'd5, 5'd7, 5'd10, 5'd12};
    localparam logic [19:0] WORD_C = {5'd15, 5'd14, 5'd13, 5'd11};
    localparam logic [19:0] WORD_Z = {5'd1, 5'd1, 5'd1, 5'd1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        loadValid = 1'b0;
    logic        loadReady;
    logic [19:0] loadData = '0;
    logic [4:0]  line;
    logic [6:0]  segIn;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frameTick;
`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  loadDp = 4'b0101;
    logic        dp;
`endif

    typedef struct {
        logic        en;
        logic        valid;
        logic [19:0] data;
        logic        accept;
        logic [3:0]  expAn;
        logic        expTick;
        logic        expReady;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } sb_t;

    vec_t vecs [N_VECS];
    sb_t  sbQueue [$];

    int         checks = 0;
    int         failures = 0;
    logic       dpArmed = 1'b0;
    logic [3:0] prevAn = 4'hF;
    logic [6:0] prevSeg = 7'h7F;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Behavioural decoder standing in for the shared one outside the block.
    function automatic logic [6:0] decode(logic [4:0] c);
        case (c)
            5'd0:    return 7'h40;
            5'd1:    return 7'h79;
            5'd2:    return 7'h24;
            5'd3:    return 7'h30;
            5'd4:    return 7'h19;
            5'd5:    return 7'h12;
            5'd6:    return 7'h02;
            5'd7:    return 7'h78;
            5'd8:    return 7'h00;
            5'd9:    return 7'h10;
            5'd10:   return 7'h08;
            5'd11:   return 7'h03;
            5'd12:   return 7'h46;
            5'd13:   return 7'h21;
            5'd14:   return 7'h06;
            5'd15:   return 7'h0E;
            default: return 7'h3F;
        endcase
    endfunction

    assign segIn = decode(line);

    seg7_scan_ctrl #(
        .N_DIGITS  (N_DIGITS),
        .SHOW_CYC  (SHOW_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (loadValid),
        .load_ready (loadReady),
        .load_data  (loadData),
        .line       (line),
        .seg_in     (segIn),
        .seg        (seg),
        .an         (an),
        .frame_tick (frameTick)
`ifdef SEG7_SCAN_DP_EN
        ,
        .load_dp    (loadDp),
        .dp         (dp)
`endif
    );

    // Expected anodes at a given cycle counted from the first enabled edge:
    // two dark blanking cycles, then six lit cycles, per digit.
    function automatic logic [3:0] expAnAt(int pos);
        int p;
        p = pos % 32;
        if ((p % 8) < 2) return 4'hF;
        return ~(4'b0001 << (p / 8));
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then wait for the next sampling point.
    task automatic applyStimulus(logic en, logic valid, logic [19:0] data);
        enable    = en;
        loadValid = valid;
        loadData  = data;
        @(negedge clk);
    endtask

    // Queue the four lit digits a frame of this word must produce.
    task automatic pushFrame(logic [19:0] w);
        sb_t e;
        for (int k = 0; k < 4; k++) begin
            e.an  = ~(4'b0001 << k);
            e.seg = decode(w[k*5 +: 5]);
            sbQueue.push_back(e);
        end
    endtask

    // Monitor: structural checks every cycle, scoreboard pop whenever a
    // digit lights up, and segment stability while it stays lit.
    always @(negedge clk) begin
        sb_t e;
        checkOutput("an_onehot0", 32'($onehot0(~an)), 32'd1);
        if (an == 4'hF) checkOutput("seg_dark", 32'(seg), 32'h7F);
`ifdef SEG7_SCAN_DP_EN
        checkOutput("dp", 32'(dp), (dpArmed && (an == 4'hE || an == 4'hB)) ? 32'd0 : 32'd1);
`endif
        if (an != 4'hF && prevAn == 4'hF) begin
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("sb_an", 32'(an), 32'(e.an));
                checkOutput("sb_seg", 32'(seg), 32'(e.seg));
            end
        end else if (an != 4'hF && an == prevAn) begin
            checkOutput("seg_hold", 32'(seg), 32'(prevSeg));
        end
        prevAn  = an;
        prevSeg = seg;
    end

    initial begin
        // Vector table: four frames of continuous scanning with three loads.
        for (int i = 0; i < N_VECS; i++) begin
            vecs[i].en       = 1'b1;
            vecs[i].valid    = 1'b0;
            vecs[i].data     = '0;
            vecs[i].accept   = 1'b0;
            vecs[i].expAn    = expAnAt(i);
            vecs[i].expTick  = ((i % 32) == 31);
            vecs[i].expReady = !((i >= 10 && i <= 31) || (i >= 40 && i <= 63) || (i >= 65 && i <= 95));
        end
        vecs[10] = '{1'b1, 1'b1, WORD_W, 1'b1, expAnAt(10), 1'b0, 1'b0};
        vecs[40] = '{1'b1, 1'b1, WORD_A, 1'b1, expAnAt(40), 1'b0, 1'b0};
        vecs[41] = '{1'b1, 1'b1, WORD_B, 1'b0, expAnAt(41), 1'b0, 1'b0};
        vecs[42] = '{1'b1, 1'b1, WORD_C, 1'b0, expAnAt(42), 1'b0, 1'b0};
        vecs[64] = '{1'b1, 1'b1, WORD_B, 1'b0, expAnAt(64), 1'b0, 1'b1};
        vecs[65] = '{1'b1, 1'b1, WORD_B, 1'b1, expAnAt(65), 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_ready", 32'(loadReady), 32'd1);
        checkOutput("rst_tick", 32'(frameTick), 32'd0);
        checkOutput("rst_line", 32'(line), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("idle_an", 32'(an), 32'hF);

        pushFrame(20'h0);
        for (int i = 0; i < N_VECS; i++) begin
            if (vecs[i].accept) pushFrame(vecs[i].data);
            if (i == 32) dpArmed = 1'b1;
            applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].expAn));
            checkOutput($sformatf("vec%0d_tick", i), 32'(frameTick), 32'(vecs[i].expTick));
            checkOutput($sformatf("vec%0d_ready", i), 32'(loadReady), 32'(vecs[i].expReady));
        end
        checkOutput("sb_drained_table", sbQueue.size(), 32'd0);

        // Drop enable while digit 2 is lit, then re-enable.
        for (int k = 128; k < 148; k++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("pre_drop_an", 32'(an), 32'hB);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("drop_an", 32'(an), 32'hF);
        checkOutput("drop_seg", 32'(seg), 32'h7F);
        checkOutput("drop_tick", 32'(frameTick), 32'd0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("dark_an", 32'(an), 32'hF);
        end
        pushFrame(WORD_B);
        for (int j = 0; j < 32; j++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("reen%0d_an", j), 32'(an), 32'(expAnAt(j)));
            checkOutput($sformatf("reen%0d_tick", j), 32'(frameTick), (j == 31) ? 32'd1 : 32'd0);
        end

        // Offer a word, then reset asynchronously mid-SHOW.
        applyStimulus(1'b1, 1'b1, WORD_Z);
        checkOutput("z_pending_ready", 32'(loadReady), 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("pre_rst_an", 32'(an), 32'hE);
        #2 rst_n = 1'b0;
        dpArmed = 1'b0;
        #1;
        checkOutput("async_rst_an", 32'(an), 32'hF);
        checkOutput("async_rst_seg", 32'(seg), 32'h7F);
        checkOutput("async_rst_ready", 32'(loadReady), 32'd1);
        checkOutput("async_rst_tick", 32'(frameTick), 32'd0);
        checkOutput("async_rst_line", 32'(line), 32'd0);
        enable    = 1'b0;
        loadValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // The discarded word must not appear: the display stays all zeros.
        pushFrame(20'h0);
        for (int j = 0; j < 32; j++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("post%0d_an", j), 32'(an), 32'(expAnAt(j)));
            checkOutput($sformatf("post%0d_ready", j), 32'(loadReady), 32'd1);
        end
        checkOutput("sb_drained_end", sbQueue.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
